// File: rtl/mark1_seq_pkg.sv
// mark1_seq_pkg: shared types and constants for the mark1 control-decode sequencer.
// Holds the FSM state enum, bus widths, named decoder output bit positions and
// the illegal-encoding predicate used by mark1_ctrl_sequencer.
package mark1_seq_pkg;

    localparam int unsigned INSN_W    = 20;
    localparam int unsigned CTL_W     = 31;
    localparam int unsigned VALID_BIT = 0;

    // Decoder outputs asserted for words whose x00 (valid) input is clear.
    localparam int unsigned Z01_BIT = 1;
    localparam int unsigned Z16_BIT = 16;
    localparam int unsigned Z17_BIT = 17;
    localparam int unsigned Z21_BIT = 21;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ISSUE  = 2'd2,
        TRAP   = 2'd3
    } state_e;

    // A word claiming to be valid that decodes to no control lines at all.
    function automatic logic is_illegal(input logic [INSN_W-1:0] insn,
                                        input logic [CTL_W-1:0]  ctl);
        return insn[VALID_BIT] && (ctl == '0);
    endfunction

endpackage

// File: rtl/mark1_ctrl_sequencer.sv
// mark1_ctrl_sequencer: sequences instruction words through the external
// combinational mark1 control-decode PLA and issues the decoded control word.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     instruction handshake, in_word[19:0] = x19..x00
//   dec_in[19:0]          registered word driven to decoder inputs
//   dec_out[30:0]         decoder outputs z30..z00
//   ctl_valid/ctl_ready   control-word handshake, ctl_word[30:0]
//   trap_valid            one-cycle pulse on illegal encoding
//   trap_word[19:0]       offending instruction, held until the next trap
//   busy                  FSM not idle
//   issue_cnt[CNT_W-1:0]  completed control handshakes (wrapping)
//
// Optional feature: define MARK1_SEQ_SKID_EN for a one-entry input skid register
// that lets a new word be accepted during ISSUE/TRAP.
module mark1_ctrl_sequencer
    import mark1_seq_pkg::*;
#(
    parameter int unsigned DEC_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [19:0]       in_word,
    output logic [19:0]       dec_in,
    input  logic [30:0]       dec_out,
    output logic              ctl_valid,
    input  logic              ctl_ready,
    output logic [30:0]       ctl_word,
    output logic              trap_valid,
    output logic [19:0]       trap_word,
    output logic              busy,
    output logic [CNT_W-1:0]  issue_cnt
);

    localparam int unsigned WAIT_W = 2;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                in_ready_q, in_ready_d;
    logic [INSN_W-1:0]   dec_in_q, dec_in_d;
    logic                ctl_valid_q, ctl_valid_d;
    logic [CTL_W-1:0]    ctl_word_q, ctl_word_d;
    logic                trap_valid_q, trap_valid_d;
    logic [INSN_W-1:0]   trap_word_q, trap_word_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                accept_c;
    logic                handshake_c;
    logic                pend_vld_c;
    logic [INSN_W-1:0]   pend_word_c;

`ifdef MARK1_SEQ_SKID_EN
    logic                skid_full_q, skid_full_d;
    logic [INSN_W-1:0]   skid_q, skid_d;
`endif

    assign accept_c    = in_valid && in_ready_q;
    assign handshake_c = ctl_valid_q && ctl_ready;

    // Word available to start a new decode when leaving ISSUE or TRAP.
`ifdef MARK1_SEQ_SKID_EN
    assign pend_vld_c  = skid_full_q || accept_c;
    assign pend_word_c = skid_full_q ? skid_q : in_word;
`else
    assign pend_vld_c  = 1'b0;
    assign pend_word_c = in_word;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        dec_in_d     = dec_in_q;
        ctl_valid_d  = ctl_valid_q;
        ctl_word_d   = ctl_word_q;
        trap_valid_d = 1'b0;
        trap_word_d  = trap_word_q;
        cnt_d        = cnt_q;
`ifdef MARK1_SEQ_SKID_EN
        skid_full_d  = skid_full_q;
        skid_d       = skid_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    dec_in_d = in_word;
                    wait_d   = WAIT_W'(DEC_LAT - 1);
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_W'(1);
                end else if (is_illegal(dec_in_q, dec_out)) begin
                    trap_valid_d = 1'b1;
                    trap_word_d  = dec_in_q;
                    state_d      = TRAP;
                end else begin
                    ctl_word_d  = dec_out;
                    ctl_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (handshake_c) begin
                    ctl_valid_d = 1'b0;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = IDLE;
                    if (pend_vld_c) begin
                        dec_in_d = pend_word_c;
                        wait_d   = WAIT_W'(DEC_LAT - 1);
                        state_d  = DECODE;
`ifdef MARK1_SEQ_SKID_EN
                        skid_full_d = 1'b0;
`endif
                    end
                end
`ifdef MARK1_SEQ_SKID_EN
                else if (accept_c) begin
                    skid_full_d = 1'b1;
                    skid_d      = in_word;
                end
`endif
            end
            TRAP: begin
                state_d = IDLE;
                if (pend_vld_c) begin
                    dec_in_d = pend_word_c;
                    wait_d   = WAIT_W'(DEC_LAT - 1);
                    state_d  = DECODE;
`ifdef MARK1_SEQ_SKID_EN
                    skid_full_d = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
`ifdef MARK1_SEQ_SKID_EN
        in_ready_d = (state_d == IDLE) ||
                     (((state_d == ISSUE) || (state_d == TRAP)) && !skid_full_d);
`else
        in_ready_d = (state_d == IDLE);
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            in_ready_q   <= 1'b1;
            dec_in_q     <= '0;
            ctl_valid_q  <= 1'b0;
            ctl_word_q   <= '0;
            trap_valid_q <= 1'b0;
            trap_word_q  <= '0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
`ifdef MARK1_SEQ_SKID_EN
            skid_full_q  <= 1'b0;
            skid_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            in_ready_q   <= in_ready_d;
            dec_in_q     <= dec_in_d;
            ctl_valid_q  <= ctl_valid_d;
            ctl_word_q   <= ctl_word_d;
            trap_valid_q <= trap_valid_d;
            trap_word_q  <= trap_word_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
`ifdef MARK1_SEQ_SKID_EN
            skid_full_q  <= skid_full_d;
            skid_q       <= skid_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign dec_in     = dec_in_q;
    assign ctl_valid  = ctl_valid_q;
    assign ctl_word   = ctl_word_q;
    assign trap_valid = trap_valid_q;
    assign trap_word  = trap_word_q;
    assign busy       = busy_q;
    assign issue_cnt  = cnt_q;

endmodule
